// File: rtl/reg_file.sv
// Register file (2^A x W, two async read ports, one sync write) plus ALU flag/SC latch.
// Reads combinational, writes and flag captures land on the next edge; no back-pressure.
module reg_file #(
    parameter int W = 8,
    parameter int A = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [A-1:0] i_raddr_a,
    input  logic [A-1:0] i_raddr_b,
    input  logic [A-1:0] i_waddr,
    input  logic         i_write_en,
    input  logic [W-1:0] i_data_in,
    output logic [W-1:0] o_data_out_a,
    output logic [W-1:0] o_data_out_b,
    input  logic         i_flag_en,
    input  logic         i_zero_in,
    input  logic         i_parity_in,
    input  logic         i_odd_in,
    input  logic         i_carry_in,
    input  logic         i_sc_clr,
    output logic         o_zero_q,
    output logic         o_parity_q,
    output logic         o_odd_q,
    output logic         o_sc_out
);

    localparam int N = 2 ** A;

    logic [W-1:0] r_mem [N];
    logic         r_zero;
    logic         r_parity;
    logic         r_odd;
    logic         r_sc;

    // No write bypass: a port reading the write address sees the old value until the edge.
    assign o_data_out_a = r_mem[i_raddr_a];
    assign o_data_out_b = r_mem[i_raddr_b];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < N; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_write_en) begin
            r_mem[i_waddr] <= i_data_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_zero   <= 1'b0;
            r_parity <= 1'b0;
            r_odd    <= 1'b0;
        end else if (i_flag_en) begin
            r_zero   <= i_zero_in;
            r_parity <= i_parity_in;
            r_odd    <= i_odd_in;
        end
    end

    // ScClr beats a simultaneous capture so a chain can be restarted on the same cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sc <= 1'b0;
        end else if (i_sc_clr) begin
            r_sc <= 1'b0;
        end else if (i_flag_en) begin
            r_sc <= i_carry_in;
        end
    end

    assign o_zero_q   = r_zero;
    assign o_parity_q = r_parity;
    assign o_odd_q    = r_odd;
    assign o_sc_out   = r_sc;

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset sweep, write/read, read-during-write, flags, SC priority.
module tb_reg_file;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] raddr_a, raddr_b, waddr;
    logic       write_en;
    logic [7:0] data_in;
    logic [7:0] data_out_a, data_out_b;
    logic       flag_en, zero_in, parity_in, odd_in, carry_in, sc_clr;
    logic       zero_q, parity_q, odd_q, sc_out;

    int n_checks = 0;
    int n_fail   = 0;

    reg_file #(.W(8), .A(4)) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_raddr_a    (raddr_a),
        .i_raddr_b    (raddr_b),
        .i_waddr      (waddr),
        .i_write_en   (write_en),
        .i_data_in    (data_in),
        .o_data_out_a (data_out_a),
        .o_data_out_b (data_out_b),
        .i_flag_en    (flag_en),
        .i_zero_in    (zero_in),
        .i_parity_in  (parity_in),
        .i_odd_in     (odd_in),
        .i_carry_in   (carry_in),
        .i_sc_clr     (sc_clr),
        .o_zero_q     (zero_q),
        .o_parity_q   (parity_q),
        .o_odd_q      (odd_q),
        .o_sc_out     (sc_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; write_en = 1'b0; flag_en = 1'b0; sc_clr = 1'b0;
        waddr = 4'd0; data_in = 8'h00; raddr_a = 4'd0; raddr_b = 4'd0;
        zero_in = 1'b0; parity_in = 1'b0; odd_in = 1'b0; carry_in = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            raddr_a = 4'(i);
            raddr_b = 4'(15 - i);
            #1;
            n_checks++;
            if (data_out_a !== 8'h00 || data_out_b !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_scan addr=%0d got A=%h B=%h expected 00/00", i, data_out_a, data_out_b);
            end
        end
        n_checks++;
        if ({zero_q, parity_q, odd_q, sc_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b expected 0000", {zero_q, parity_q, odd_q, sc_out});
        end
    endtask

    task automatic test_write_read();
        write_en = 1'b1; waddr = 4'd3; data_in = 8'hA5;
        tick();
        waddr = 4'd12; data_in = 8'h3C;
        tick();
        write_en = 1'b0; waddr = 4'd3; data_in = 8'hEE;
        raddr_a = 4'd3; raddr_b = 4'd12;
        #1;
        n_checks++;
        if (data_out_a !== 8'hA5 || data_out_b !== 8'h3C) begin
            n_fail++;
            $display("FAIL write_read got A=%h B=%h expected A5/3C", data_out_a, data_out_b);
        end
        tick();
        n_checks++;
        if (data_out_a !== 8'hA5) begin
            n_fail++;
            $display("FAIL write_disabled got %h expected A5", data_out_a);
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 3 || i == 12) continue;
            raddr_b = 4'(i);
            #1;
            n_checks++;
            if (data_out_b !== 8'h00) begin
                n_fail++;
                $display("FAIL untouched_reg addr=%0d got %h expected 00", i, data_out_b);
            end
        end
    endtask

    task automatic test_read_during_write();
        write_en = 1'b1; waddr = 4'd5; data_in = 8'h11;
        tick();
        data_in = 8'h22; raddr_a = 4'd5;
        #1;
        n_checks++;
        if (data_out_a !== 8'h11) begin
            n_fail++;
            $display("FAIL rdw_same_cycle got %h expected 11", data_out_a);
        end
        tick();
        write_en = 1'b0;
        #1;
        n_checks++;
        if (data_out_a !== 8'h22) begin
            n_fail++;
            $display("FAIL rdw_next_cycle got %h expected 22", data_out_a);
        end
    endtask

    task automatic test_flags();
        flag_en = 1'b1; zero_in = 1'b1; parity_in = 1'b0; odd_in = 1'b1; carry_in = 1'b1;
        tick();
        flag_en = 1'b0;
        n_checks++;
        if ({zero_q, parity_q, odd_q, sc_out} !== 4'b1011) begin
            n_fail++;
            $display("FAIL flag_capture got %b expected 1011", {zero_q, parity_q, odd_q, sc_out});
        end
        zero_in = 1'b0; parity_in = 1'b1; odd_in = 1'b0; carry_in = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({zero_q, parity_q, odd_q, sc_out} !== 4'b1011) begin
            n_fail++;
            $display("FAIL flag_hold got %b expected 1011", {zero_q, parity_q, odd_q, sc_out});
        end
    endtask

    task automatic test_sc_priority();
        sc_clr = 1'b1; flag_en = 1'b1; carry_in = 1'b1;
        zero_in = 1'b0; parity_in = 1'b1; odd_in = 1'b0;
        tick();
        sc_clr = 1'b0; flag_en = 1'b0;
        n_checks++;
        if ({zero_q, parity_q, odd_q, sc_out} !== 4'b0100) begin
            n_fail++;
            $display("FAIL sc_clr_priority got %b expected 0100", {zero_q, parity_q, odd_q, sc_out});
        end
        flag_en = 1'b1;
        tick();
        flag_en = 1'b0;
        n_checks++;
        if (sc_out !== 1'b1) begin
            n_fail++;
            $display("FAIL sc_recapture got %b expected 1", sc_out);
        end
        write_en = 1'b1; waddr = 4'd7; data_in = 8'h5A;
        tick();
        reset = 1'b1; data_in = 8'hFF; flag_en = 1'b1; zero_in = 1'b1; odd_in = 1'b1;
        tick();
        reset = 1'b0; write_en = 1'b0; flag_en = 1'b0;
        raddr_a = 4'd7; raddr_b = 4'd3;
        #1;
        n_checks++;
        if (data_out_a !== 8'h00 || data_out_b !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_midrun_regs got r7=%h r3=%h expected 00/00", data_out_a, data_out_b);
        end
        n_checks++;
        if ({zero_q, parity_q, odd_q, sc_out} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_midrun_flags got %b expected 0000", {zero_q, parity_q, odd_q, sc_out});
        end
    endtask

    task automatic test_back_to_back();
        write_en = 1'b1; waddr = 4'd9; data_in = 8'h80;
        tick();
        write_en = 1'b0;
        raddr_a = 4'd9; raddr_b = 4'd9;
        #1;
        n_checks++;
        if (data_out_a !== 8'h80 || data_out_b !== 8'h80) begin
            n_fail++;
            $display("FAIL dual_read got A=%h B=%h expected 80/80", data_out_a, data_out_b);
        end
        write_en = 1'b1; data_in = 8'h01;
        flag_en = 1'b1; zero_in = 1'b0; parity_in = 1'b1; odd_in = 1'b0; carry_in = 1'b0;
        tick();
        write_en = 1'b0; flag_en = 1'b0;
        n_checks++;
        if (data_out_a !== 8'h01 || data_out_b !== 8'h01) begin
            n_fail++;
            $display("FAIL write_with_flag_data got A=%h B=%h expected 01/01", data_out_a, data_out_b);
        end
        n_checks++;
        if ({zero_q, parity_q, odd_q, sc_out} !== 4'b0100) begin
            n_fail++;
            $display("FAIL write_with_flag_flags got %b expected 0100", {zero_q, parity_q, odd_q, sc_out});
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_read_during_write();
        test_flags();
        test_sc_priority();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Register file with a status-flag latch, sitting directly upstream of the ALU. It holds 2^A general registers of W bits and drives the ALU's two operand inputs from two asynchronous read ports. It takes one synchronous write per cycle from writeback, latches the ALU's Zero/Parity/Odd flags plus an externally computed carry, and drives the registered shift/carry bit into the ALU's SC_in.

## Interface
- W, default 8: data width in bits; must match ALU W.
- A, default 4: address width; the register count is 2^A.

- Clk  input  1: clock; all state updates on the rising edge.
- Reset  input  1: synchronous, active-high; sampled on the rising edge of Clk.
- RaddrA  input  A: read address for port A.
- RaddrB  input  A: read address for port B.
- Waddr  input  A: write address.
- WriteEn  input  1: write DataIn to register Waddr at the next edge.
- DataIn  input  W: write data, i.e. the ALU Out or a memory load.
- DataOutA  output  W: contents of register RaddrA; feeds ALU InputA.
- DataOutB  output  W: contents of register RaddrB; feeds ALU InputB.
- FlagEn  input  1: capture the flag inputs at the next edge.
- ZeroIn, ParityIn, OddIn  input  1 each: ALU status flags.
- CarryIn  input  1: carry/shifted-out bit supplied by the datapath.
- ScClr  input  1: clear the SC latch at the next edge.
- ZeroQ, ParityQ, OddQ  output  1 each: latched flags used by the branch logic.
- ScOut  output  1: latched carry; feeds ALU SC_in.

## Operation
- Storage: 2^A registers of W bits each. All registers are writable, including register 0; there is no hardwired zero.
- Reads are combinational.
  - DataOutA = reg[RaddrA] and DataOutB = reg[RaddrB], both reflecting state after the last edge.
  - Both ports may address the same register and both return the same value.
- Writes: on the rising edge with WriteEn=1 and Reset=0, reg[Waddr] <= DataIn. With WriteEn=0 the storage is unchanged.
- Read-during-write: no bypass. If RaddrA or RaddrB equals Waddr while WriteEn=1, the port shows the old value for that cycle and the new value after the edge.
- Flag latch: on the edge with FlagEn=1, ZeroQ/ParityQ/OddQ <= ZeroIn/ParityIn/OddIn. With FlagEn=0 the flags hold.
- SC latch, priority per edge: Reset, then ScClr, then FlagEn.
  - ScClr=1 gives ScOut <= 0.
  - Otherwise FlagEn=1 gives ScOut <= CarryIn.
  - Otherwise ScOut holds.
- WriteEn and FlagEn are independent and may both be asserted in the same cycle.
- Reset: all registers, ZeroQ, ParityQ, OddQ and ScOut become 0 at the edge. Reset overrides WriteEn, FlagEn and ScClr in the same cycle.
- Arithmetic: none. Data passes through unmodified at width W. Addresses are full-decode with no out-of-range case.

## Timing
- Read latency 0 cycles: combinational from address and state.
- Write latency 1 edge. A value written at edge N is readable immediately after edge N.
- Flag/SC latency 1 edge. ScOut reaches the ALU one cycle after the operation that produced CarryIn, which supports multi-byte shift/add chains.
- Reset values after the first Reset edge:
  - DataOutA = DataOutB = 0 for every address.
  - ZeroQ = ParityQ = OddQ = ScOut = 0.
- Before the first Reset, contents are undefined. The bench must apply Reset for at least 1 cycle first.
- Reset asserted mid-sequence: any write or flag capture in that cycle is discarded and all state is 0 on the following cycle.
- No handshake: every write is accepted the cycle it is presented. No stall or back-pressure exists.

## Test plan
- Reset then scan: assert Reset for 1 cycle, then sweep RaddrA/RaddrB over 0..15 -> every read is 0x00; ZeroQ=ParityQ=OddQ=ScOut=0.
- Write and read back: write reg[3]=0xA5 and reg[12]=0x3C on consecutive cycles; then RaddrA=3, RaddrB=12 -> DataOutA=0xA5, DataOutB=0x3C; all other registers still 0.
- Read-during-write: reg[5]=0x11, then WriteEn with Waddr=5, DataIn=0x22, RaddrA=5 -> DataOutA=0x11 in that cycle and 0x22 the next cycle.
- Flag capture and hold: FlagEn=1 with ZeroIn=1, ParityIn=0, OddIn=1, CarryIn=1 -> next cycle ZeroQ=1, ParityQ=0, OddQ=1, ScOut=1. Then FlagEn=0 with all inputs inverted -> outputs unchanged.
- SC priority: ScClr=1 and FlagEn=1 with CarryIn=1 -> ScOut=0 and the other flags captured. Then Reset=1 with WriteEn=1, Waddr=7, DataIn=0xFF -> reg[7]=0x00 and all flags 0.
- Same-address dual read plus simultaneous write and flag: RaddrA=RaddrB=9 after writing 0x80 -> both ports read 0x80. In one cycle, write reg[9]=0x01 with FlagEn=1, ParityIn=1 -> next cycle reg[9]=0x01 and ParityQ=1.
